// File: rtl/simple_cpu_pkg.sv
// Shared opcode and FSM state definitions for the parameterised processor.
package simple_cpu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_BNZ  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_t;

  // Opcodes whose result comes from the ALU and which update Z and C.
  function automatic logic is_alu_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/param_alu.sv
// Combinational ALU: ADD/SUB/XOR/SHL with zero and carry/borrow outputs.
module param_alu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              z,
  output logic              c
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    y = a;
    c = 1'b0;
    case (opcode_t'(op))
      OP_ADD: {c, y} = {1'b0, a} + {1'b0, b};
      // Top bit of the widened difference is the borrow.
      OP_SUB: {c, y} = {1'b0, a} - {1'b0, b};
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        c = a[DATA_W-1];
        y = {a[DATA_W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

  assign z = (y == '0);

endmodule

// File: rtl/param_processor.sv
// Small multi-cycle processor: program loaded by write, run by start,
// FETCH/DECODE/EXEC per instruction, reports result on a done pulse.
module param_processor
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NREGS      = 16,
  parameter int PROG_DEPTH = 16,
  localparam int REG_AW    = $clog2(NREGS),
  localparam int PC_W      = $clog2(PROG_DEPTH),
  localparam int INSTR_W   = OP_W + 2*REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write,
  input  logic [INSTR_W-1:0] program_in,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               ovf,
  output logic [DATA_W-1:0]  result,
  output logic               flag_z,
  output logic               flag_c
);

  localparam logic [PC_W:0] DEPTH = (PC_W+1)'(PROG_DEPTH);

  state_t              state;
  logic [PC_W:0]       pc;
  logic [PC_W:0]       wptr;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [INSTR_W-1:0]  prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0]   regs [NREGS];

  opcode_t             ir_op;
  logic [REG_AW-1:0]   ir_rx;
  logic [REG_AW-1:0]   ir_ry;
  logic [DATA_W-1:0]   ir_imm;

  assign ir_op  = opcode_t'(ir[INSTR_W-1 -: OP_W]);
  assign ir_rx  = ir[INSTR_W-OP_W-1 -: REG_AW];
  assign ir_ry  = ir[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
  assign ir_imm = ir[DATA_W-1:0];

  logic [DATA_W-1:0] alu_y;
  logic              alu_z;
  logic              alu_c;

  param_alu #(.DATA_W(DATA_W)) u_alu (
    .op (ir_op),
    .a  (opa),
    .b  (opb),
    .y  (alu_y),
    .z  (alu_z),
    .c  (alu_c)
  );

  // A write is only accepted in IDLE, loses to start, and stops at full.
  logic mem_we;
  assign mem_we = (state == S_IDLE) && write && !start && (wptr != DEPTH);

  // NOTE: program memory has no reset; clearing wptr makes old words
  // unreachable, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      prog_mem[wptr[PC_W-1:0]] <= program_in;
    end
  end

  // Execute-stage decisions, applied by the FSM on the EXEC edge.
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic              flags_we;
  logic [PC_W:0]     pc_next;
  logic [PC_W:0]     bnz_target;
  logic              run_end;
  logic              run_err;
  logic [DATA_W-1:0] end_result;

  always_comb begin
    reg_we     = 1'b0;
    reg_wdata  = alu_y;
    flags_we   = is_alu_op(ir_op);
    pc_next    = pc + 1'b1;
    bnz_target = {1'b0, ir_imm[PC_W-1:0]};
    run_end    = 1'b0;
    run_err    = 1'b0;
    case (ir_op)
      OP_LOAD: begin
        reg_we    = 1'b1;
        reg_wdata = ir_imm;
      end
      OP_MOV: begin
        reg_we    = 1'b1;
        reg_wdata = opb;
      end
      OP_ADD, OP_SUB, OP_XOR, OP_SHL: reg_we = 1'b1;
      OP_BNZ: begin
        if (opa != '0) begin
          pc_next = bnz_target;
          if (bnz_target >= wptr) begin
            run_end = 1'b1;
            run_err = 1'b1;
          end
        end
      end
      OP_HALT: run_end = 1'b1;
      default: ;
    endcase
    if (!run_end && (pc_next == wptr)) begin
      run_end = 1'b1;
    end

    // Falling off the end reports R0 as it stands after this instruction.
    if (ir_op == OP_HALT) begin
      end_result = opa;
    end else if (run_err) begin
      end_result = '0;
    end else if (reg_we && (ir_rx == '0)) begin
      end_result = reg_wdata;
    end else begin
      end_result = regs[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      wptr   <= '0;
      ir     <= '0;
      opa    <= '0;
      opb    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc  <= '0;
            err <= 1'b0;
            if (wptr == '0) begin
              state  <= S_DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
            end else begin
              state <= S_FETCH;
              busy  <= 1'b1;
            end
          end else if (write) begin
            if (wptr == DEPTH) begin
              ovf <= 1'b1;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        S_FETCH: begin
          ir    <= prog_mem[pc[PC_W-1:0]];
          state <= S_DECODE;
        end
        S_DECODE: begin
          opa   <= regs[ir_rx];
          opb   <= regs[ir_ry];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (reg_we) begin
            regs[ir_rx] <= reg_wdata;
          end
          if (flags_we) begin
            flag_z <= alu_z;
            flag_c <= alu_c;
          end
          if (run_end) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            err    <= run_err;
            result <= end_result;
          end else begin
            state <= S_FETCH;
            pc    <= pc_next;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
